fp8_mean_sq_accum: RTL and testbench

// - Streaming mean-of-squares reducer; sits directly upstream of the fp8 square-root stage (RMS-norm path).
// - Consumes a vector of 2**LOG2_LEN fp8 elements over a valid/ready stream.
// - Squares each element exactly and accumulates in wide fixed point, divides by the length (exponent shift).
// - Emits one rounded, non-negative fp8 mean ready for sqrt.
// - fp8 format: [7] sign, [6:3] exp (bias 7), [2:0] mant. All codes are finite (no Inf/NaN).
//   - exp==0: value = mant * 2^-9 (subnormal)
//   - else:   value = (8+mant) * 2^(exp-10)

---
 rtl/fp8_mean_sq_accum.sv | 86 ++++++++
 tb/tb_fp8_mean_sq_accum.sv | 114 +++++++++++
 2 files changed

// File: rtl/fp8_mean_sq_accum.sv
// fp8_mean_sq_accum: streaming fp8 mean-of-squares reducer producing a rounded non-negative fp8 mean
module fp8_mean_sq_accum #(
  parameter int LOG2_LEN = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);
  localparam int ACC_W = 36 + LOG2_LEN;
  localparam int CW = LOG2_LEN > 0 ? LOG2_LEN : 1;
  localparam int LEN = 1 << LOG2_LEN;
  localparam int S = 9 + LOG2_LEN;
  typedef enum logic [1:0] {ACCUM, CONV, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic sq_v_q, sq_v_d;
  logic [35:0] sq_r_q, sq_r_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [3:0] sig, e_eff;
  logic [35:0] sq;
  logic hs, last;
  int p, be;
  logic [ACC_W-1:0] norm;
  logic [4:0] rnd;
  logic [3:0] m;
  logic [7:0] conv;
  assign in_ready_o = (state_q == ACCUM) & ~done_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign hs = in_valid_i & in_ready_o;
  assign last = cnt_q == CW'(LEN - 1);
  always_comb begin
    sig = {|in_data_i[6:3], in_data_i[2:0]};
    e_eff = |in_data_i[6:3] ? in_data_i[6:3] : 4'd1;
    sq = (36'(sig) * 36'(sig)) << {e_eff - 4'd1, 1'b0};
  end
  always_comb begin
    p = 0;
    for (int i = 0; i < ACC_W; i++) p = acc_q[i] ? i : p;
    norm = acc_q << (ACC_W - 1 - p);
    rnd = {2'b01, norm[ACC_W-2 -: 3]} + 5'(norm[ACC_W-5] & ((|norm[ACC_W-6:0]) | norm[ACC_W-4]));
    be = p - 11 - LOG2_LEN + int'(rnd[4]);
    m = {1'b0, acc_q[S+2:S]} + 4'(acc_q[S-1] & ((|acc_q[S-2:0]) | acc_q[S]));
    conv = p < 12 + LOG2_LEN ? {4'b0000, m} : be > 15 ? 8'h7F : {1'b0, be[3:0], rnd[2:0]};
  end
  always_comb begin
    cnt_d = hs ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    done_d = ~done_q & hs & last;
    sq_v_d = hs;
    sq_r_d = hs ? sq : sq_r_q;
    acc_d = (state_q == OUT && out_ready_i) ? '0 : sq_v_q ? acc_q + ACC_W'(sq_r_q) : acc_q;
    state_d = state_q == ACCUM ? (done_q ? CONV : ACCUM) :
              state_q == CONV ? OUT : (out_ready_i ? ACCUM : OUT);
    out_valid_d = state_q == CONV ? 1'b1 : (out_valid_q & out_ready_i) ? 1'b0 : out_valid_q;
    out_data_d = state_q == CONV ? conv : out_data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      done_q <= 1'b0;
      sq_v_q <= 1'b0;
      sq_r_q <= '0;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      sq_v_q <= sq_v_d;
      sq_r_q <= sq_r_d;
      acc_q <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_fp8_mean_sq_accum.sv
// tb_fp8_mean_sq_accum: directed self-checking bench for fp8_mean_sq_accum with LOG2_LEN=2
module tb_fp8_mean_sq_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  int n = 0;
  int fails = 0;
  logic [7:0] held;
  fp8_mean_sq_accum #(.LOG2_LEN(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .in_data_i(in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .out_data_o(out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    in_data = d;
    in_valid = 1'b1;
    chk("in_ready_accum", {7'b0, in_ready}, 8'h01);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic vec(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] exp,
                     input logic accept);
    send(d0);
    send(d1);
    send(d2);
    send(d3);
    chk({tag, "_k_valid"}, {7'b0, out_valid}, 8'h00);
    chk({tag, "_k_ready"}, {7'b0, in_ready}, 8'h00);
    tick();
    chk({tag, "_k1_valid"}, {7'b0, out_valid}, 8'h00);
    tick();
    chk({tag, "_k2_valid"}, {7'b0, out_valid}, 8'h01);
    chk({tag, "_data"}, out_data, exp);
    if (accept) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_acc_valid"}, {7'b0, out_valid}, 8'h00);
      chk({tag, "_acc_ready"}, {7'b0, in_ready}, 8'h01);
    end
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    vec("one", 8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 1'b1);
    out_ready = 1'b1;
    vec("mix", 8'h38, 8'h40, 8'h00, 8'h00, 8'h3A, 1'b1);
    vec("neg", 8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'h38, 1'b1);
    vec("sat", 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
    vec("uflow", 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
    vec("rne", 8'h39, 8'h39, 8'h39, 8'h39, 8'h3A, 1'b1);
    vec("zero", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    vec("subn", 8'h18, 8'h18, 8'h18, 8'h98, 8'h02, 1'b1);
    vec("stall", 8'h40, 8'h40, 8'h40, 8'h40, 8'h48, 1'b0);
    held = out_data;
    in_data = 8'h7F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {7'b0, out_valid}, 8'h01);
      chk("stall_data", out_data, 8'h48);
      chk("stall_ready", {7'b0, in_ready}, 8'h00);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_rel_valid", {7'b0, out_valid}, 8'h00);
    vec("after_stall", 8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 1'b1);
    vec("pend", 8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid2", {7'b0, out_valid}, 8'h00);
    chk("rst_out_data2", out_data, 8'h00);
    chk("rst_in_ready2", {7'b0, in_ready}, 8'h01);
    send(8'h7F);
    send(8'h7F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready", {7'b0, in_ready}, 8'h01);
    vec("post_rst", 8'h40, 8'h40, 8'h40, 8'h40, 8'h48, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
